// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase sequencer: phase codes, light patterns
// and default phase durations in seconds.
package traffic_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [2:0] light_t;

  localparam phase_t MAIN_GREEN  = 3'd0;
  localparam phase_t MAIN_YELLOW = 3'd1;
  localparam phase_t ALL_RED_A   = 3'd2;
  localparam phase_t SIDE_GREEN  = 3'd3;
  localparam phase_t SIDE_YELLOW = 3'd4;
  localparam phase_t ALL_RED_B   = 3'd5;

  // Light vectors are {R,Y,G}
  localparam light_t RED = 3'b100;
  localparam light_t YEL = 3'b010;
  localparam light_t GRN = 3'b001;

  localparam int unsigned DEF_T_MAIN_MIN   = 20;
  localparam int unsigned DEF_T_MAIN_MAX   = 45;
  localparam int unsigned DEF_T_YELLOW     = 4;
  localparam int unsigned DEF_T_ALL_RED    = 2;
  localparam int unsigned DEF_T_SIDE_GREEN = 15;

endpackage

// File: rtl/phase_light_decode.sv
// Combinational phase -> light decode; any code outside the six legal phases shows
// red on both roads.
module phase_light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] phase,
  output logic [2:0] main_light,
  output logic [2:0] side_light
);

  always_comb begin
    main_light = RED;
    side_light = RED;
    case (phase)
      MAIN_GREEN:  main_light = GRN;
      MAIN_YELLOW: main_light = YEL;
      SIDE_GREEN:  side_light = GRN;
      SIDE_YELLOW: side_light = YEL;
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Two-road phase sequencer closing a timing loop with an external one-second counter:
// it reads elapsed seconds on count and pulses reset_count on every phase change.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int unsigned T_MAIN_MIN   = DEF_T_MAIN_MIN,
  parameter int unsigned T_MAIN_MAX   = DEF_T_MAIN_MAX,
  parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
  parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
  parameter int unsigned T_SIDE_GREEN = DEF_T_SIDE_GREEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] count,
  input  logic       side_req,
  output logic       reset_count,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase
);

  localparam logic [5:0] TH_MAIN_MIN   = 6'(T_MAIN_MIN);
  localparam logic [5:0] TH_MAIN_MAX   = 6'(T_MAIN_MAX);
  localparam logic [5:0] TH_YELLOW     = 6'(T_YELLOW);
  localparam logic [5:0] TH_ALL_RED    = 6'(T_ALL_RED);
  localparam logic [5:0] TH_SIDE_GREEN = 6'(T_SIDE_GREEN);

  logic [2:0] phase_q, phase_d, next_phase;
  logic       reset_count_q, reset_count_d;
  logic       armed_q, armed_d;
  logic       req_q, req_d;
  logic [2:0] main_light_q, main_light_d;
  logic [2:0] side_light_q, side_light_d;
  logic       expired;
  logic       illegal;

  always_comb begin
    phase_d       = phase_q;
    reset_count_d = 1'b0;
    armed_d       = armed_q;
    req_d         = req_q | side_req;
    next_phase    = phase_q;
    expired       = 1'b0;
    illegal       = 1'b0;

    // Arm only once the counter is seen cleared, so stale counts cannot retrigger
    if (!reset_count_q && (count == 6'd0)) armed_d = 1'b1;

    case (phase_q)
      MAIN_GREEN: begin
        next_phase = MAIN_YELLOW;
        expired    = (req_q && (count >= TH_MAIN_MIN)) || (count >= TH_MAIN_MAX);
      end
      MAIN_YELLOW: begin
        next_phase = ALL_RED_A;
        expired    = (count >= TH_YELLOW);
      end
      ALL_RED_A: begin
        next_phase = SIDE_GREEN;
        expired    = (count >= TH_ALL_RED);
      end
      SIDE_GREEN: begin
        next_phase = SIDE_YELLOW;
        expired    = (count >= TH_SIDE_GREEN);
      end
      SIDE_YELLOW: begin
        next_phase = ALL_RED_B;
        expired    = (count >= TH_YELLOW);
      end
      ALL_RED_B: begin
        next_phase = MAIN_GREEN;
        expired    = (count >= TH_ALL_RED);
      end
      default: begin
        next_phase = ALL_RED_B;
        illegal    = 1'b1;
      end
    endcase

    if ((armed_q && expired) || illegal) begin
      phase_d       = next_phase;
      reset_count_d = 1'b1;
      armed_d       = 1'b0;
    end

    // A request arriving on the very edge that serves the side road is kept
    if ((phase_d == SIDE_GREEN) && (phase_q != SIDE_GREEN)) req_d = side_req;
  end

  phase_light_decode u_decode (
    .phase      (phase_d),
    .main_light (main_light_d),
    .side_light (side_light_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= ALL_RED_B;
      reset_count_q <= 1'b1;
      armed_q       <= 1'b0;
      req_q         <= 1'b0;
      main_light_q  <= RED;
      side_light_q  <= RED;
    end else begin
      phase_q       <= phase_d;
      reset_count_q <= reset_count_d;
      armed_q       <= armed_d;
      req_q         <= req_d;
      main_light_q  <= main_light_d;
      side_light_q  <= side_light_d;
    end
  end

  assign phase       = phase_q;
  assign reset_count = reset_count_q;
  assign main_light  = main_light_q;
  assign side_light  = side_light_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm closed around a behavioural one-second counter
// that advances every 4 clocks; phase entries are scored against an expected queue.
module tb_traffic_phase_fsm;

  localparam logic [2:0] P_MG  = 3'd0;
  localparam logic [2:0] P_MY  = 3'd1;
  localparam logic [2:0] P_ARA = 3'd2;
  localparam logic [2:0] P_SG  = 3'd3;
  localparam logic [2:0] P_SY  = 3'd4;
  localparam logic [2:0] P_ARB = 3'd5;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] count = 6'd0;
  logic       side_req;
  logic       reset_count;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  logic [1:0] tick = 2'd0;
  logic       rc_dly = 1'b0;
  logic       delay_clear = 1'b0;
  logic       rst_edge = 1'b0;
  logic       mon_on = 1'b0;
  logic       mon_seq = 1'b0;
  logic [2:0] last_phase = 3'd5;
  logic       changed;
  logic       main_go, side_go;

  traffic_phase_fsm #(
    .T_MAIN_MIN   (3),
    .T_MAIN_MAX   (6),
    .T_YELLOW     (2),
    .T_ALL_RED    (1),
    .T_SIDE_GREEN (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .side_req    (side_req),
    .reset_count (reset_count),
    .main_light  (main_light),
    .side_light  (side_light),
    .phase       (phase)
  );

  // clock / counter model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rc_dly   <= reset_count;
    rst_edge <= reset;
    if (delay_clear ? rc_dly : reset_count) begin
      count <= 6'd0;
      tick  <= 2'd0;
    end else if (tick == 2'd3) begin
      tick  <= 2'd0;
      count <= count + 6'd1;
    end else begin
      tick <= tick + 2'd1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_entry(input logic [2:0] p, input logic [5:0] c);
    exp_q.push_back({p, c});
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((phase != p) && (n < 300));
    check("wait_phase", int'(phase), int'(p));
  endtask

  task automatic wait_count(input logic [5:0] c);
    int n = 0;
    while ((count != c) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check("wait_count", int'(count), int'(c));
  endtask

  task automatic check_lights(input string tag, input logic [2:0] m, input logic [2:0] s);
    check({tag, "_main"}, int'(main_light), int'(m));
    check({tag, "_side"}, int'(side_light), int'(s));
  endtask

  task automatic pulse_req();
    side_req = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
  endtask

  // per-cycle monitor: safety, one-hot lights, reset_count pulses, phase entry order
  always @(negedge clk) begin
    if (mon_on) begin
      changed = (phase != last_phase);
      main_go = (main_light == 3'b001) || (main_light == 3'b010);
      side_go = (side_light == 3'b001) || (side_light == 3'b010);
      check("safety", int'(main_go && side_go), 0);
      check("main_onehot", int'($onehot(main_light)), 1);
      check("side_onehot", int'($onehot(side_light)), 1);
      check("rc_pulse", int'(reset_count), int'(changed || rst_edge));
      if (changed && mon_seq) begin
        if (exp_q.size() == 0) begin
          check("seq_extra", int'({phase, count}), -1);
        end else begin
          exp_e = exp_q.pop_front();
          check("seq", int'({phase, count}), int'(exp_e));
        end
      end
    end
    last_phase = phase;
  end

  initial begin
    reset    = 1'b1;
    side_req = 1'b0;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    check("rst_phase", int'(phase), int'(P_ARB));
    check_lights("rst", 3'b100, 3'b100);
    check("rst_rc", int'(reset_count), 1);
    check("rst_armed", int'(dut.armed_q), 0);
    check("rst_req", int'(dut.req_q), 0);

    // reset release, no request: full cycle with main green ending at max
    push_entry(P_MG, 6'd1);  push_entry(P_MY, 6'd6);  push_entry(P_ARA, 6'd2);
    push_entry(P_SG, 6'd1);  push_entry(P_SY, 6'd4);  push_entry(P_ARB, 6'd2);
    push_entry(P_MG, 6'd1);
    mon_seq = 1'b1;
    reset   = 1'b0;
    @(negedge clk);
    check("rel_rc", int'(reset_count), 0);
    check("rel_armed", int'(dut.armed_q), 0);
    @(negedge clk);
    check("rel_armed2", int'(dut.armed_q), 1);
    wait_phase(P_MG);  check_lights("mg", 3'b001, 3'b100);
    wait_phase(P_MY);  check_lights("my", 3'b010, 3'b100);
    wait_phase(P_ARA); check_lights("ara", 3'b100, 3'b100);
    wait_phase(P_SG);  check_lights("sg", 3'b100, 3'b001);
    wait_phase(P_SY);  check_lights("sy", 3'b100, 3'b010);
    wait_phase(P_ARB); check_lights("arb", 3'b100, 3'b100);
    wait_phase(P_MG);

    // early request at count 1: honoured only at the minimum
    push_entry(P_MY, 6'd3);  push_entry(P_ARA, 6'd2); push_entry(P_SG, 6'd1);
    push_entry(P_SY, 6'd4);  push_entry(P_ARB, 6'd2); push_entry(P_MG, 6'd1);
    wait_count(6'd0);
    wait_count(6'd1);
    pulse_req();
    check("early_req_latch", int'(dut.req_q), 1);
    wait_phase(P_MY);
    wait_phase(P_ARA);
    check("early_req_held", int'(dut.req_q), 1);
    wait_phase(P_SG);
    check("early_req_clear", int'(dut.req_q), 0);
    wait_phase(P_MG);

    // late request at count 5, then a request landing on the side-green entry edge
    push_entry(P_MY, 6'd5);  push_entry(P_ARA, 6'd2); push_entry(P_SG, 6'd1);
    push_entry(P_SY, 6'd4);  push_entry(P_ARB, 6'd2); push_entry(P_MG, 6'd1);
    wait_count(6'd0);
    wait_count(6'd5);
    pulse_req();
    wait_phase(P_MY);
    wait_phase(P_ARA);
    wait_count(6'd0);
    wait_count(6'd1);
    pulse_req();
    check("setwins_phase", int'(phase), int'(P_SG));
    check("setwins_req", int'(dut.req_q), 1);
    wait_phase(P_MG);

    // stale count: the counter clears one clock late
    push_entry(P_MY, 6'd3);  push_entry(P_ARA, 6'd2); push_entry(P_SG, 6'd1);
    delay_clear = 1'b1;
    wait_phase(P_MY);
    repeat (2) @(negedge clk);
    check("stale_armed", int'(dut.armed_q), 0);
    check("stale_no_double", int'(phase), int'(P_MY));
    @(negedge clk);
    check("stale_armed_late", int'(dut.armed_q), 1);
    wait_phase(P_ARA);
    wait_phase(P_SG);
    delay_clear = 1'b0;

    // re-latch in side green, then reset mid-phase at count 2
    wait_count(6'd0);
    pulse_req();
    check("relatch_req", int'(dut.req_q), 1);
    wait_count(6'd2);
    check("mid_pre_phase", int'(phase), int'(P_SG));
    mon_seq = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_phase", int'(phase), int'(P_ARB));
    check_lights("mid", 3'b100, 3'b100);
    check("mid_req", int'(dut.req_q), 0);
    check("mid_rc", int'(reset_count), 1);
    check("mid_armed", int'(dut.armed_q), 0);
    @(negedge clk);
    push_entry(P_MG, 6'd1);
    mon_seq = 1'b1;
    wait_phase(P_MG);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
